// File: rtl/arith_pkg.sv
// Shared definitions for the arithmetic datapath: the controller state encoding
// and the default operand width used by both the serial and parallel units.
package arith_pkg;

  localparam int ARITH_WIDTH = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage : arith_pkg

// File: rtl/full_subtractor.sv
// One-bit full subtractor: d = x - y - bin, with borrow-out.
// This is the subtract counterpart of the ripple adder's full-adder cell.
module full_subtractor (
  input  logic x,
  input  logic y,
  input  logic bin,
  output logic d,
  output logic bout
);

  assign d    = x ^ y ^ bin;
  assign bout = (~x & y) | (~(x ^ y) & bin);

endmodule : full_subtractor

// File: rtl/serial_subtractor.sv
// Bit-serial DIFF = A - B - BIN, LSB first, one bit per clock through a single
// full-subtractor cell, behind a start/busy/done handshake.
module serial_subtractor
  import arith_pkg::*;
#(
  parameter int WIDTH = ARITH_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             BIN,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] DIFF,
  output logic             BOUT
);

  localparam int CNT_W = $clog2(WIDTH);

  state_t state, state_next;

  logic [WIDTH-1:0] a_sr, b_sr, res_sr;
  logic             borrow_q;
  logic [CNT_W-1:0] cnt;
  logic             cell_d, cell_bout;
  logic             accept, last_bit;

  full_subtractor u_cell (
    .x   (a_sr[0]),
    .y   (b_sr[0]),
    .bin (borrow_q),
    .d   (cell_d),
    .bout(cell_bout)
  );

  assign accept   = start && (state == IDLE || state == DONE);
  assign last_bit = (state == RUN) && (cnt == CNT_W'(WIDTH - 1));

  always_comb begin
    // NOTE: default first so every path assigns state_next; no latch is inferred.
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = RUN;
      RUN:     if (last_bit) state_next = DONE;
      DONE:    state_next = start ? RUN : IDLE;
      default: state_next = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // NOTE: the whole datapath is reset, not only the control state, so that an
  // aborted operation leaves no residue in the shift registers or borrow.
  always_ff @(posedge clk) begin
    if (rst) begin
      a_sr     <= '0;
      b_sr     <= '0;
      res_sr   <= '0;
      borrow_q <= 1'b0;
      cnt      <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      DIFF     <= '0;
      BOUT     <= 1'b0;
    end else begin
      busy <= (state_next == RUN);
      done <= last_bit;
      if (accept) begin
        a_sr     <= A;
        b_sr     <= B;
        borrow_q <= BIN;
        cnt      <= '0;
      end else if (state == RUN) begin
        // Result bits enter at the MSB so the LSB lands at bit 0 after WIDTH shifts.
        a_sr     <= a_sr >> 1;
        b_sr     <= b_sr >> 1;
        res_sr   <= {cell_d, res_sr[WIDTH-1:1]};
        borrow_q <= cell_bout;
        cnt      <= cnt + CNT_W'(1);
        if (last_bit) begin
          DIFF <= {cell_d, res_sr[WIDTH-1:1]};
          BOUT <= cell_bout;
        end
      end
    end
  end

endmodule : serial_subtractor

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor: directed, exhaustive and randomized
// operations scored against a plain-arithmetic model of A - B - BIN.
module tb_serial_subtractor;

  localparam int WIDTH = 4;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             start = 1'b0;
  logic [WIDTH-1:0] A = '0;
  logic [WIDTH-1:0] B = '0;
  logic             BIN = 1'b0;
  logic             busy, done, BOUT;
  logic [WIDTH-1:0] DIFF;

  int checks = 0;
  int failures = 0;

  serial_subtractor #(.WIDTH(WIDTH)) dut (
    .clk  (clk),
    .rst  (rst),
    .start(start),
    .A    (A),
    .B    (B),
    .BIN  (BIN),
    .busy (busy),
    .done (done),
    .DIFF (DIFF),
    .BOUT (BOUT)
  );

  always #5 clk = ~clk;

  // Advance one edge and settle just after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // {BOUT, DIFF} is the (WIDTH+1)-bit wrap of the integer difference.
  function automatic logic [WIDTH:0] ref_sub(input int a, input int b, input int bin);
    int r;
    r = a - b - bin;
    return (WIDTH+1)'(r & ((1 << (WIDTH + 1)) - 1));
  endfunction

  task automatic scramble_inputs();
    A   = WIDTH'($urandom);
    B   = WIDTH'($urandom);
    BIN = 1'($urandom);
  endtask

  // Issue one operation from IDLE and check the full handshake and result.
  task automatic run_op(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                        input logic bin, input logic [WIDTH:0] exp, input string tag);
    A = a; B = b; BIN = bin; start = 1'b1;
    tick();
    start = 1'b0;
    scramble_inputs();
    for (int i = 0; i < WIDTH; i++) begin
      checks++;
      if (busy !== 1'b1 || done !== 1'b0) begin
        failures++;
        $display("FAIL %s run%0d: busy=%b done=%b, expected busy=1 done=0", tag, i, busy, done);
      end
      tick();
    end
    checks++;
    if (done !== 1'b1 || busy !== 1'b0) begin
      failures++;
      $display("FAIL %s complete: busy=%b done=%b, expected busy=0 done=1", tag, busy, done);
    end
    checks++;
    if ({BOUT, DIFF} !== exp) begin
      failures++;
      $display("FAIL %s result: a=%h b=%h bin=%b got BOUT=%b DIFF=%h, expected BOUT=%b DIFF=%h",
               tag, a, b, bin, BOUT, DIFF, exp[WIDTH], exp[WIDTH-1:0]);
    end
    tick();
    checks++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL %s after: busy=%b done=%b, expected 0 0", tag, busy, done);
    end
  endtask

  task automatic check_cleared(input string tag);
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || DIFF !== '0 || BOUT !== 1'b0) begin
      failures++;
      $display("FAIL %s: busy=%b done=%b DIFF=%h BOUT=%b, expected all 0", tag, busy, done, DIFF, BOUT);
    end
  endtask

  // Watch n cycles and require that no done pulse appears.
  task automatic expect_quiet(input int n, input string tag);
    int pulses = 0;
    for (int i = 0; i < n; i++) begin
      tick();
      if (done === 1'b1) pulses++;
    end
    checks++;
    if (pulses != 0) begin
      failures++;
      $display("FAIL %s: saw %0d extra done pulses, expected 0", tag, pulses);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    check_cleared("reset_state");
    expect_quiet(3, "reset_idle");
  endtask

  task automatic test_directed();
    run_op(4'h9, 4'h3, 1'b0, 5'h06, "d_9_3_0");
    run_op(4'h3, 4'h9, 1'b0, 5'h1A, "d_3_9_0");
    run_op(4'h0, 4'h0, 1'b1, 5'h1F, "d_0_0_1");
    run_op(4'hF, 4'hF, 1'b1, 5'h1F, "d_F_F_1");
    run_op(4'hF, 4'h0, 1'b0, 5'h0F, "d_F_0_0");
  endtask

  task automatic test_exhaustive();
    for (int a = 0; a < (1 << WIDTH); a++)
      for (int b = 0; b < (1 << WIDTH); b++)
        for (int c = 0; c < 2; c++)
          run_op(WIDTH'(a), WIDTH'(b), 1'(c), ref_sub(a, b, c), "exhaustive");
  endtask

  task automatic test_start_ignored();
    A = 4'h9; B = 4'h3; BIN = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
    scramble_inputs();
    tick();
    A = 4'h1; B = 4'h1; BIN = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    checks++;
    if (done !== 1'b1 || {BOUT, DIFF} !== 5'h06) begin
      failures++;
      $display("FAIL ignore_start: done=%b BOUT=%b DIFF=%h, expected done=1 BOUT=0 DIFF=6",
               done, BOUT, DIFF);
    end
    expect_quiet(8, "ignore_start_no_second_done");
  endtask

  task automatic test_back_to_back(input logic [WIDTH-1:0] a1, input logic [WIDTH-1:0] b1,
                                   input logic c1, input logic [WIDTH-1:0] a2,
                                   input logic [WIDTH-1:0] b2, input logic c2, input string tag);
    logic [WIDTH:0] exp1, exp2;
    exp1 = ref_sub(int'(a1), int'(b1), int'(c1));
    exp2 = ref_sub(int'(a2), int'(b2), int'(c2));
    A = a1; B = b1; BIN = c1; start = 1'b1;
    tick();
    start = 1'b0;
    scramble_inputs();
    for (int i = 0; i < WIDTH; i++) tick();
    checks++;
    if (done !== 1'b1 || {BOUT, DIFF} !== exp1) begin
      failures++;
      $display("FAIL %s first: done=%b {BOUT,DIFF}=%h, expected done=1 %h", tag, done, {BOUT, DIFF}, exp1);
    end
    A = a2; B = b2; BIN = c2; start = 1'b1;
    tick();
    start = 1'b0;
    scramble_inputs();
    for (int i = 0; i < WIDTH; i++) begin
      checks++;
      if (busy !== 1'b1 || done !== 1'b0 || {BOUT, DIFF} !== exp1) begin
        failures++;
        $display("FAIL %s hold%0d: busy=%b done=%b {BOUT,DIFF}=%h, expected 1 0 %h",
                 tag, i, busy, done, {BOUT, DIFF}, exp1);
      end
      tick();
    end
    checks++;
    if (done !== 1'b1 || {BOUT, DIFF} !== exp2) begin
      failures++;
      $display("FAIL %s second: done=%b {BOUT,DIFF}=%h, expected done=1 %h", tag, done, {BOUT, DIFF}, exp2);
    end
    tick();
  endtask

  task automatic test_reset_mid_run();
    run_op(4'h9, 4'h3, 1'b0, 5'h06, "pre_abort");
    A = WIDTH'($urandom); B = WIDTH'($urandom); BIN = 1'($urandom); start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_cleared("abort_cleared");
    expect_quiet(8, "abort_no_done");
    check_cleared("abort_still_cleared");
    begin
      logic [WIDTH-1:0] a, b;
      logic c;
      a = WIDTH'($urandom); b = WIDTH'($urandom); c = 1'($urandom);
      run_op(a, b, c, ref_sub(int'(a), int'(b), int'(c)), "after_abort");
    end
  endtask

  task automatic test_random();
    for (int n = 0; n < 30; n++) begin
      logic [WIDTH-1:0] a, b;
      logic c;
      a = WIDTH'($urandom); b = WIDTH'($urandom); c = 1'($urandom);
      run_op(a, b, c, ref_sub(int'(a), int'(b), int'(c)), "random");
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_exhaustive();
    test_start_ignored();
    test_back_to_back(4'h9, 4'h3, 1'b0, 4'h5, 4'h7, 1'b0, "b2b_directed");
    for (int n = 0; n < 6; n++)
      test_back_to_back(WIDTH'($urandom), WIDTH'($urandom), 1'($urandom),
                        WIDTH'($urandom), WIDTH'($urandom), 1'($urandom), "b2b_random");
    test_reset_mid_run();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_serial_subtractor
